timekeeper_ctrl: RTL and testbench

Controller for the digital clock's time-of-day datapath. It holds hours/minutes/seconds as packed BCD, advances them on the 1 Hz tick with cascaded mod-60/mod-60/mod-24 carries, and runs the mode FSM that lets the user stop the clock and set individual fields from two push-buttons. It sits between the tick generator / button debouncers and the seven-segment display driver.

---
 rtl/timekeeper_ctrl.sv | 131 +++++++++++++
 tb/tb_timekeeper_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper_ctrl.sv
// Time-of-day controller: packed-BCD hh:mm:ss with tick-driven carries and a button-driven set-mode FSM.
// Define TIMEKEEPER_SEC_SET_EN to compile in the SET_SEC state (seconds clear via btn_inc).
module timekeeper_ctrl #(
    parameter logic [7:0] INIT_HOUR = 8'h12,
    parameter logic [7:0] INIT_MIN  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [1:0] mode,
    output logic       blink,
    output logic       chime
);

`ifdef TIMEKEEPER_SEC_SET_EN
    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] hour_q, min_q, sec_q;
    logic [7:0] hour_d, min_d, sec_d;
    logic       phase_q, phase_d;
    logic       blink_q, blink_d;
    logic       chime_q, chime_d;

    // Wraps to 00 at maxv explicitly, so no field ever depends on a nibble overflow.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
`ifdef TIMEKEEPER_SEC_SET_EN
                SET_MIN:  state_d = SET_SEC;
                SET_SEC:  state_d = RUN;
`else
                SET_MIN:  state_d = RUN;
`endif
                default:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        chime_d = 1'b0;
        phase_d = tick ? ~phase_q : phase_q;

        if (state_q == RUN) begin
            if (tick) begin
                sec_d = bcd_inc(sec_q, 8'h59);
                if (sec_q == 8'h59) begin
                    min_d = bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) begin
                        hour_d  = bcd_inc(hour_q, 8'h23);
                        chime_d = 1'b1;
                    end
                end
            end
            if (btn_mode)
                phase_d = 1'b0;
        end else if (btn_mode) begin
`ifndef TIMEKEEPER_SEC_SET_EN
            if (state_q == SET_MIN)
                sec_d = 8'h00;
`endif
        end else if (btn_inc) begin
            case (state_q)
                SET_HOUR: hour_d = bcd_inc(hour_q, 8'h23);
                SET_MIN:  min_d  = bcd_inc(min_q, 8'h59);
`ifdef TIMEKEEPER_SEC_SET_EN
                SET_SEC:  sec_d  = 8'h00;
`endif
                default:  ;
            endcase
        end

        blink_d = (state_d != RUN) ? phase_d : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hour_q  <= INIT_HOUR;
            min_q   <= INIT_MIN;
            sec_q   <= 8'h00;
            phase_q <= 1'b0;
            blink_q <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            chime_q <= chime_d;
        end
    end

    assign hour  = hour_q;
    assign min   = min_q;
    assign sec   = sec_q;
    assign mode  = state_q;
    assign blink = blink_q;
    assign chime = chime_q;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Bench for timekeeper_ctrl: integer reference model feeds a scoreboard queue, plus directed constant checks.
module tb_timekeeper_ctrl;

`ifdef TIMEKEEPER_SEC_SET_EN
    localparam int LAST_MODE = 3;
`else
    localparam int LAST_MODE = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] hour, min, sec;
    logic [1:0] mode;
    logic       blink, chime;

    timekeeper_ctrl #(.INIT_HOUR(8'h12), .INIT_MIN(8'h00)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour(hour), .min(min), .sec(sec), .mode(mode), .blink(blink), .chime(chime)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] h, m, s;
        logic [1:0] md;
        logic       bl, ch;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    int m_h, m_m, m_s, m_md, m_ph, m_bl, m_ch;

    function automatic logic [7:0] tobcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic model(input logic t, input logic bm, input logic bi, input logic r);
        int nmd;
        if (r) begin
            m_h = 12; m_m = 0; m_s = 0; m_md = 0; m_ph = 0; m_bl = 0; m_ch = 0;
            return;
        end
        m_ch = 0;
        if (m_md == 0 && t) begin
            m_s++;
            if (m_s == 60) begin
                m_s = 0; m_m++;
                if (m_m == 60) begin
                    m_m = 0; m_h = (m_h + 1) % 24; m_ch = 1;
                end
            end
        end
        if (t) m_ph = 1 - m_ph;
        nmd = m_md;
        if (bm) begin
            nmd = (m_md == LAST_MODE) ? 0 : m_md + 1;
            if (m_md == 0) m_ph = 0;
            if (m_md == 2 && LAST_MODE == 2) m_s = 0;
        end else if (bi) begin
            if (m_md == 1) m_h = (m_h + 1) % 24;
            if (m_md == 2) m_m = (m_m + 1) % 60;
            if (m_md == 3) m_s = 0;
        end
        m_md = nmd;
        m_bl = (m_md != 0) ? m_ph : 0;
    endtask

    task automatic step(input logic t, input logic bm, input logic bi, input logic r);
        exp_t e;
        tick = t; btn_mode = bm; btn_inc = bi; reset = r;
        model(t, bm, bi, r);
        e.h = tobcd(m_h); e.m = tobcd(m_m); e.s = tobcd(m_s);
        e.md = 2'(m_md); e.bl = 1'(m_bl); e.ch = 1'(m_ch);
        sb.push_back(e);
        @(posedge clk);
        #1;
        tick = 0; btn_mode = 0; btn_inc = 0; reset = 0;
        e = sb.pop_front();
        chk("sb_hour", hour, e.h);
        chk("sb_min", min, e.m);
        chk("sb_sec", sec, e.s);
        chk("sb_mode", {6'd0, mode}, {6'd0, e.md});
        chk("sb_blink", {7'd0, blink}, {7'd0, e.bl});
        chk("sb_chime", {7'd0, chime}, {7'd0, e.ch});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0);
    endtask

    // From SET_MIN back to RUN, passing through SET_SEC when it exists.
    task automatic leave_set_min();
        step(0, 1, 0, 0);
        if (LAST_MODE == 3) step(0, 1, 0, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_hour", hour, 8'h12);
        chk("rst_min", min, 8'h00);
        chk("rst_sec", sec, 8'h00);
        chk("rst_mode", {6'd0, mode}, 8'd0);
        chk("rst_blink", {7'd0, blink}, 8'd0);
        chk("rst_chime", {7'd0, chime}, 8'd0);

        ticks(61);
        chk("run61_hour", hour, 8'h12);
        chk("run61_min", min, 8'h01);
        chk("run61_sec", sec, 8'h01);

        step(0, 1, 0, 0);
        chk("seth_blink0", {7'd0, blink}, 8'd0);
        incs(13);
        chk("seth_hour", hour, 8'h01);
        step(1, 0, 0, 0);
        chk("blink_t1", {7'd0, blink}, 8'd1);
        step(1, 0, 0, 0);
        chk("blink_t2", {7'd0, blink}, 8'd0);
        step(1, 0, 0, 0);
        chk("blink_t3", {7'd0, blink}, 8'd1);
        chk("frozen_sec", sec, 8'h01);
        chk("frozen_min", min, 8'h01);

        step(0, 1, 0, 0);
        incs(60);
        chk("setm_min", min, 8'h01);
        chk("setm_hour", hour, 8'h01);
        step(0, 1, 0, 0);
        if (LAST_MODE == 3) begin
            chk("sets_mode", {6'd0, mode}, 8'd3);
            step(0, 0, 1, 0);
            chk("sets_sec", sec, 8'h00);
            step(0, 1, 0, 0);
        end else begin
            chk("exit_sec", sec, 8'h00);
        end
        chk("back_run_mode", {6'd0, mode}, 8'd0);
        chk("back_run_blink", {7'd0, blink}, 8'd0);

        step(0, 1, 1, 0);
        chk("modeinc_mode", {6'd0, mode}, 8'd1);
        chk("modeinc_hour", hour, 8'h01);
        step(1, 0, 1, 0);
        chk("tickinc_hour", hour, 8'h02);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("midset_rst_hour", hour, 8'h12);
        chk("midset_rst_min", min, 8'h00);
        chk("midset_rst_sec", sec, 8'h00);
        chk("midset_rst_mode", {6'd0, mode}, 8'd0);

        step(0, 1, 0, 0);
        incs(11);
        step(0, 1, 0, 0);
        incs(59);
        leave_set_min();
        ticks(58);
        chk("pre_hms", hour, 8'h23);
        chk("pre_sec", sec, 8'h58);
        step(1, 0, 0, 0);
        chk("c59_sec", sec, 8'h59);
        chk("c59_chime", {7'd0, chime}, 8'd0);
        step(1, 0, 0, 0);
        chk("wrap_hour", hour, 8'h00);
        chk("wrap_min", min, 8'h00);
        chk("wrap_sec", sec, 8'h00);
        chk("wrap_chime", {7'd0, chime}, 8'd1);
        step(0, 0, 0, 0);
        chk("chime_drop", {7'd0, chime}, 8'd0);

        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        incs(59);
        leave_set_min();
        ticks(59);
        step(1, 1, 0, 0);
        chk("modetick_hour", hour, 8'h13);
        chk("modetick_min", min, 8'h00);
        chk("modetick_sec", sec, 8'h00);
        chk("modetick_chime", {7'd0, chime}, 8'd1);
        chk("modetick_mode", {6'd0, mode}, 8'd1);
        step(1, 0, 1, 0);
        chk("set_tickinc_hour", hour, 8'h14);
        chk("set_chime_quiet", {7'd0, chime}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
